// File: rtl/pingpong_pkg.sv
// Shared types and constants for the pingpong game-flow logic.
package pingpong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CDOWN  = 3'd1,
    ST_FLIGHT = 3'd2,
    ST_HIT    = 3'd3,
    ST_POINT  = 3'd4,
    ST_OVER   = 3'd5
  } state_e;

  localparam logic DIR_TO_A = 1'b0;
  localparam logic DIR_TO_B = 1'b1;

  localparam logic SERVER_A = 1'b0;
  localparam logic SERVER_B = 1'b1;

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned PER_W   = 16;

  localparam logic [1:0] CD_START = 2'd3;

  // Score increment that sticks at the top of the score range.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == '1) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Enabled wrap-around counter producing a one-cycle pulse at terminal count.
module tick_divider #(
  parameter int unsigned DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned       CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over counting so a state change restarts the tick phase.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/serve_sequencer.sv
// Rally-level game controller: serve countdown, ball stepping, hit windows
// and scoring, all timed from a single millisecond tick.
module serve_sequencer
  import pingpong_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned CD_MS    = 1000,
  parameter int unsigned STEP_MS  = 200,
  parameter int unsigned LANE     = 8,
  parameter int unsigned WIN      = 11,
  parameter int unsigned POS_W    = $clog2(LANE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hit_a,
  input  logic               hit_b,
  output logic [POS_W-1:0]   ball_pos,
  output logic               ball_dir,
  output logic [1:0]         countdown,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               point_a,
  output logic               point_b,
  output logic               game_over,
  output logic [2:0]         state
);

  localparam logic [POS_W-1:0]   POS_A     = '0;
  localparam logic [POS_W-1:0]   POS_B     = POS_W'(LANE - 1);
  localparam logic [PER_W-1:0]   CD_LAST   = PER_W'(CD_MS - 1);
  localparam logic [PER_W-1:0]   STEP_LAST = PER_W'(STEP_MS - 1);
  localparam logic [SCORE_W-1:0] WIN_SC    = SCORE_W'(WIN);

  state_e             state_q, state_d;
  logic [PER_W-1:0]   per_q, per_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               dir_q, dir_d;
  logic [1:0]         cd_q, cd_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d;
  logic [SCORE_W-1:0] score_b_q, score_b_d;
  logic               point_a_q, point_a_d;
  logic               point_b_q, point_b_d;
  logic               over_q, over_d;
  logic               server_q, server_d;

  logic               tick;
  logic               tick_en;
  logic               state_chg;
  logic [PER_W-1:0]   per_last;
  logic               period_done;
  logic               hit_valid;
  logic [POS_W-1:0]   pos_step;

  assign tick_en   = (state_q != ST_IDLE) && (state_q != ST_OVER);
  assign state_chg = (state_d != state_q);

  tick_divider #(
    .DIV (TICK_DIV)
  ) u_tick_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_en),
    .clr   (state_chg),
    .tick  (tick)
  );

  // Period length selection and completion detect.
  always_comb begin
    per_last    = CD_LAST;
    if ((state_q == ST_FLIGHT) || (state_q == ST_HIT)) per_last = STEP_LAST;
    period_done = tick && (per_q == per_last);
    hit_valid   = (dir_q == DIR_TO_B) ? hit_b : hit_a;
    pos_step    = (dir_q == DIR_TO_B) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
  end

  // Period counter: restarts on any state change and on each completion.
  always_comb begin
    per_d = per_q;
    if (state_chg || period_done) per_d = '0;
    else if (tick)                per_d = per_q + PER_W'(1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    cd_d      = cd_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    point_a_d = point_a_q;
    point_b_d = point_b_q;
    over_d    = over_q;
    server_d  = server_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CDOWN;
          cd_d    = CD_START;
          pos_d   = (server_q == SERVER_A) ? POS_A : POS_B;
        end
      end

      ST_CDOWN: begin
        if (period_done) begin
          if (cd_q == 2'd1) begin
            state_d = ST_FLIGHT;
            cd_d    = '0;
            pos_d   = (server_q == SERVER_A) ? POS_A : POS_B;
            dir_d   = (server_q == SERVER_A) ? DIR_TO_B : DIR_TO_A;
          end else begin
            cd_d = cd_q - 2'd1;
          end
        end
      end

      ST_FLIGHT: begin
        if (period_done) begin
          pos_d = pos_step;
          if (pos_step == ((dir_q == DIR_TO_B) ? POS_B : POS_A)) state_d = ST_HIT;
        end
      end

      // A valid swing is checked before window expiry so a swing on the
      // final cycle of the window still counts as a return.
      ST_HIT: begin
        if (hit_valid) begin
          dir_d   = ~dir_q;
          state_d = ST_FLIGHT;
        end else if (period_done) begin
          state_d = ST_POINT;
          if (dir_q == DIR_TO_B) begin
            score_a_d = sat_inc(score_a_q);
            point_a_d = 1'b1;
          end else begin
            score_b_d = sat_inc(score_b_q);
            point_b_d = 1'b1;
          end
        end
      end

      ST_POINT: begin
        if (period_done) begin
          point_a_d = 1'b0;
          point_b_d = 1'b0;
          if ((point_a_q && (score_a_q == WIN_SC)) ||
              (point_b_q && (score_b_q == WIN_SC))) begin
            state_d = ST_OVER;
            over_d  = 1'b1;
          end else begin
            server_d = point_a_q ? SERVER_B : SERVER_A;
            state_d  = ST_CDOWN;
            cd_d     = CD_START;
            pos_d    = point_a_q ? POS_B : POS_A;
          end
        end
      end

      ST_OVER: begin
        if (start) begin
          score_a_d = '0;
          score_b_d = '0;
          server_d  = SERVER_A;
          over_d    = 1'b0;
          state_d   = ST_CDOWN;
          cd_d      = CD_START;
          pos_d     = POS_A;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      per_q     <= '0;
      pos_q     <= '0;
      dir_q     <= 1'b0;
      cd_q      <= '0;
      score_a_q <= '0;
      score_b_q <= '0;
      point_a_q <= 1'b0;
      point_b_q <= 1'b0;
      over_q    <= 1'b0;
      server_q  <= SERVER_A;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      cd_q      <= cd_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      point_a_q <= point_a_d;
      point_b_q <= point_b_d;
      over_q    <= over_d;
      server_q  <= server_d;
    end
  end

  assign ball_pos  = pos_q;
  assign ball_dir  = dir_q;
  assign countdown = cd_q;
  assign score_a   = score_a_q;
  assign score_b   = score_b_q;
  assign point_a   = point_a_q;
  assign point_b   = point_b_q;
  assign game_over = over_q;
  assign state     = state_q;

endmodule

// File: tb/tb_serve_sequencer.sv
// Directed bench for serve_sequencer with a shortened time base.
module tb_serve_sequencer;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned CD_MS    = 3;
  localparam int unsigned STEP_MS  = 2;
  localparam int unsigned LANE     = 4;
  localparam int unsigned WIN      = 2;

  logic       clk = 1'b0;
  logic       rst_n, start, hit_a, hit_b;
  logic [1:0] ball_pos;
  logic       ball_dir;
  logic [1:0] countdown;
  logic [3:0] score_a, score_b;
  logic       point_a, point_b, game_over;
  logic [2:0] state;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int          now_e   = 0;

  always #5 clk = ~clk;

  serve_sequencer #(
    .TICK_DIV (TICK_DIV),
    .CD_MS    (CD_MS),
    .STEP_MS  (STEP_MS),
    .LANE     (LANE),
    .WIN      (WIN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .hit_a     (hit_a),
    .hit_b     (hit_b),
    .ball_pos  (ball_pos),
    .ball_dir  (ball_dir),
    .countdown (countdown),
    .score_a   (score_a),
    .score_b   (score_b),
    .point_a   (point_a),
    .point_b   (point_b),
    .game_over (game_over),
    .state     (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to 1 time unit after edge number e (edge 0 samples the first start).
  task automatic to_edge(input int e);
    while (now_e < e) begin
      @(posedge clk);
      now_e++;
    end
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({ball_pos, ball_dir, countdown, score_a, score_b,
                point_a, point_b, game_over, state});
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; hit_a = 1'b0; hit_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_hold", 32'(state), 32'd0);

    // Serve A: start sampled at edge 0.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    now_e = 0;
    chk("cdown_enter_state", 32'(state), 32'd1);
    chk("cdown_enter_digit", 32'(countdown), 32'd3);
    to_edge(11);  chk("digit3_held", 32'(countdown), 32'd3);
    to_edge(12);  chk("digit2", 32'(countdown), 32'd2);
    to_edge(23);  chk("digit2_held", 32'(countdown), 32'd2);
    to_edge(24);  chk("digit1", 32'(countdown), 32'd1);
    to_edge(35);  chk("digit1_held", 32'(countdown), 32'd1);
    to_edge(36);
    chk("serve_a_state", 32'(state), 32'd2);
    chk("serve_a_digit", 32'(countdown), 32'd0);
    chk("serve_a_pos", 32'(ball_pos), 32'd0);
    chk("serve_a_dir", 32'(ball_dir), 32'd1);

    // start during FLIGHT must not disturb state or step timing.
    to_edge(39); start = 1'b1;
    to_edge(40); start = 1'b0;
    chk("start_in_flight_state", 32'(state), 32'd2);
    chk("start_in_flight_digit", 32'(countdown), 32'd0);
    to_edge(43);  chk("pos0_held", 32'(ball_pos), 32'd0);
    to_edge(44);  chk("step_pos1", 32'(ball_pos), 32'd1);
    to_edge(52);  chk("step_pos2", 32'(ball_pos), 32'd2);
    to_edge(59);  chk("pre_hit_state", 32'(state), 32'd2);
    to_edge(60);
    chk("reach_b_pos", 32'(ball_pos), 32'd3);
    chk("reach_b_state", 32'(state), 32'd3);

    // Return by B three cycles into the window.
    to_edge(62); hit_b = 1'b1;
    to_edge(63); hit_b = 1'b0;
    chk("return_b_dir", 32'(ball_dir), 32'd0);
    chk("return_b_state", 32'(state), 32'd2);
    to_edge(71);  chk("back_pos2", 32'(ball_pos), 32'd2);
    to_edge(79);  chk("back_pos1", 32'(ball_pos), 32'd1);
    to_edge(87);
    chk("reach_a_pos", 32'(ball_pos), 32'd0);
    chk("reach_a_state", 32'(state), 32'd3);

    // Both swings on the final window cycle, A receiving: counts as a hit.
    to_edge(94); hit_a = 1'b1; hit_b = 1'b1;
    to_edge(95); hit_a = 1'b0; hit_b = 1'b0;
    chk("late_hit_state", 32'(state), 32'd2);
    chk("late_hit_dir", 32'(ball_dir), 32'd1);
    chk("late_hit_score_b", 32'(score_b), 32'd0);
    to_edge(119);
    chk("second_reach_b", 32'({state, ball_pos}), 32'({3'd3, 2'd3}));

    // Wrong player (A) swings during B's window: ignored, A scores on expiry.
    to_edge(121); hit_a = 1'b1;
    to_edge(122); hit_a = 1'b0;
    chk("wrong_player_state", 32'(state), 32'd3);
    chk("wrong_player_dir", 32'(ball_dir), 32'd1);
    to_edge(126); chk("window_open_score", 32'(score_a), 32'd0);
    to_edge(127);
    chk("miss_state", 32'(state), 32'd4);
    chk("miss_score_a", 32'(score_a), 32'd1);
    chk("miss_point_a", 32'({point_a, point_b}), 32'd2);
    to_edge(138); chk("point_a_held", 32'(point_a), 32'd1);
    to_edge(139);
    chk("reserve_state", 32'(state), 32'd1);
    chk("reserve_point", 32'({point_a, point_b}), 32'd0);
    chk("reserve_digit", 32'(countdown), 32'd3);
    chk("reserve_pos", 32'(ball_pos), 32'd3);
    to_edge(175);
    chk("serve_b_state", 32'(state), 32'd2);
    chk("serve_b_pos", 32'(ball_pos), 32'd3);
    chk("serve_b_dir", 32'(ball_dir), 32'd0);
    to_edge(199);
    chk("serve_b_reach_a", 32'({state, ball_pos}), 32'({3'd3, 2'd0}));

    // A returns, B misses: A reaches the winning score.
    to_edge(199); hit_a = 1'b1;
    to_edge(200); hit_a = 1'b0;
    chk("return_a_dir", 32'(ball_dir), 32'd1);
    to_edge(224); chk("final_reach_b", 32'(state), 32'd3);
    to_edge(232);
    chk("final_point", 32'({state, score_a, point_a}), 32'({3'd4, 4'd2, 1'b1}));
    to_edge(244);
    chk("over_state", 32'(state), 32'd5);
    chk("over_flag", 32'(game_over), 32'd1);
    chk("over_scores", 32'({score_a, score_b}), 32'({4'd2, 4'd0}));
    chk("over_point_clear", 32'({point_a, point_b}), 32'd0);
    to_edge(249); chk("over_scores_hold", 32'({score_a, score_b}), 32'({4'd2, 4'd0}));

    // Restart from OVER.
    start = 1'b1;
    to_edge(250); start = 1'b0;
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_scores", 32'({score_a, score_b}), 32'd0);
    chk("restart_digit", 32'(countdown), 32'd3);
    chk("restart_over_clear", 32'(game_over), 32'd0);
    chk("restart_pos", 32'(ball_pos), 32'd0);
    to_edge(286);
    chk("restart_flight", 32'({state, ball_dir}), 32'({3'd2, 1'b1}));

    // Asynchronous reset mid-FLIGHT, checked before the next clock edge.
    to_edge(290);
    #3 rst_n = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", 32'(state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
